// File: rtl/lut_probe_pkg.sv
// rtl/lut_probe_pkg.sv - shared types and sizing helpers for the LUT probe sequencer
package lut_probe_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_t;

    function automatic int vec_count(input int n_inputs);
        return 1 << n_inputs;
    endfunction

    // A one-cycle settle still needs a counter bit so the timer keeps a real register.
    function automatic int cnt_width(input int settle_cycles);
        return (settle_cycles < 2) ? 1 : $clog2(settle_cycles);
    endfunction

endpackage

// File: rtl/lut_probe_settle_timer.sv
// rtl/lut_probe_settle_timer.sv - per-vector settle countdown with zero flag
module lut_probe_settle_timer
    import lut_probe_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic zero
);

    localparam int CW = cnt_width(SETTLE_CYCLES);
    localparam logic [CW-1:0] RELOAD = CW'(SETTLE_CYCLES - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= RELOAD;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/lut_probe_sequencer.sv
// rtl/lut_probe_sequencer.sv - sweeps every LUT input vector and checks the sampled output
module lut_probe_sequencer
    import lut_probe_pkg::*;
#(
    parameter int N_INPUTS      = 3,
    parameter int SETTLE_CYCLES = 4,
    parameter logic [vec_count(N_INPUTS)-1:0] EXPECTED  = 8'hE3,
    parameter logic [vec_count(N_INPUTS)-1:0] CARE_MASK = '1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                lut_o,
    output logic [N_INPUTS-1:0] lut_i,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [N_INPUTS:0]   fail_count,
    output logic [N_INPUTS-1:0] fail_idx
);

    localparam int VEC = vec_count(N_INPUTS);
    localparam logic [N_INPUTS-1:0] LAST_VEC = N_INPUTS'(VEC - 1);

    state_t            state;
    logic              accept;
    logic              compare;
    logic              last_vec;
    logic              mismatch;
    logic              timer_zero;
    logic [N_INPUTS:0] next_count;

    assign accept     = start && ((state == IDLE) || (state == DONE));
    assign compare    = (state == SETTLE) && timer_zero;
    assign last_vec   = (lut_i == LAST_VEC);
    assign mismatch   = CARE_MASK[lut_i] && (lut_o != EXPECTED[lut_i]);
    assign next_count = fail_count + {{N_INPUTS{1'b0}}, mismatch};

    lut_probe_settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (accept || (compare && !last_vec)),
        .en   (state == SETTLE),
        .zero (timer_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            lut_i      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_count <= '0;
            fail_idx   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= SETTLE;
                        lut_i      <= '0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        fail_count <= '0;
                        fail_idx   <= '0;
                    end
                end
                SETTLE: begin
                    if (timer_zero) begin
                        if (mismatch) begin
                            fail_count <= next_count;
                            if (fail_count == '0) begin
                                fail_idx <= lut_i;
                            end
                        end
                        // pass must include the vector being judged on this same edge.
                        if (last_vec) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (next_count == '0);
                            lut_i <= '0;
                        end else begin
                            lut_i <= lut_i + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lut_probe_sequencer.sv
// tb/tb_lut_probe_sequencer.sv - self-checking bench for lut_probe_sequencer
module tb_lut_probe_sequencer;

    localparam int S   = 4;
    localparam int VEC = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Instance A: defaults, behavioural LUT from tt_a
    logic       start_a = 1'b0;
    logic [7:0] tt_a = 8'hE3;
    logic       lut_o_a;
    logic [2:0] lut_i_a;
    logic       busy_a, done_a, pass_a;
    logic [3:0] fc_a;
    logic [2:0] fi_a;
    assign lut_o_a = tt_a[lut_i_a];

    lut_probe_sequencer u_a (
        .clk(clk), .rst(rst), .start(start_a), .lut_o(lut_o_a), .lut_i(lut_i_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .fail_count(fc_a), .fail_idx(fi_a)
    );

    // Instance B: constant-0 LUT with only vectors 2..4 cared for
    logic       start_b = 1'b0;
    logic       lut_o_b = 1'b0;
    logic [2:0] lut_i_b;
    logic       busy_b, done_b, pass_b;
    logic [3:0] fc_b;
    logic [2:0] fi_b;

    lut_probe_sequencer #(.CARE_MASK(8'h1C)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .lut_o(lut_o_b), .lut_i(lut_i_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .fail_count(fc_b), .fail_idx(fi_b)
    );

    // Instance C: 2-input XOR, one-cycle settle
    logic       start_c = 1'b0;
    logic       lut_o_c;
    logic [1:0] lut_i_c;
    logic       busy_c, done_c, pass_c;
    logic [2:0] fc_c;
    logic [1:0] fi_c;
    assign lut_o_c = lut_i_c[0] ^ lut_i_c[1];

    lut_probe_sequencer #(.N_INPUTS(2), .SETTLE_CYCLES(1), .EXPECTED(4'h6), .CARE_MASK(4'hF)) u_c (
        .clk(clk), .rst(rst), .start(start_c), .lut_o(lut_o_c), .lut_i(lut_i_c),
        .busy(busy_c), .done(done_c), .pass(pass_c), .fail_count(fc_c), .fail_idx(fi_c)
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model of instance A: sweep start edge plus results computed from the truth table.
    int   cyc = 0;
    logic m_started = 1'b0;
    int   m_t0 = 0;
    int   m_fc = 0;
    int   m_fi = 0;
    int   busy_tot = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (busy_a) busy_tot <= busy_tot + 1;

    function automatic logic m_busy();
        return m_started && ((cyc - m_t0) < VEC * S);
    endfunction

    task automatic pulse_a();
        @(negedge clk);
        #1;
        if (!m_busy()) begin
            m_started = 1'b1;
            m_t0 = cyc + 1;
            m_fc = 0;
            m_fi = 0;
            for (int k = 0; k < VEC; k++) begin
                if (tt_a[k] != u_a.EXPECTED[k]) begin
                    if (m_fc == 0) m_fi = k;
                    m_fc++;
                end
            end
        end
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
    endtask

    int el;
    always @(negedge clk) begin
        if (!rst) begin
            el = cyc - m_t0;
            if (!m_started) begin
                check("idle_busy", busy_a, 0);
                check("idle_done", done_a, 0);
                check("idle_lut_i", lut_i_a, 0);
                check("idle_pass", pass_a, 0);
                check("idle_fc", fc_a, 0);
                check("idle_fi", fi_a, 0);
            end else if (el < VEC * S) begin
                check("run_busy", busy_a, 1);
                check("run_done", done_a, 0);
                check("run_pass", pass_a, 0);
                check("run_lut_i", lut_i_a, el / S);
            end else begin
                check("res_busy", busy_a, 0);
                check("res_done", done_a, 1);
                check("res_lut_i", lut_i_a, 0);
                check("res_pass", pass_a, (m_fc == 0) ? 1 : 0);
                check("res_fc", fc_a, m_fc);
                check("res_fi", fi_a, m_fi);
            end
        end
    end

    task automatic wait_done_a(input int b0, output int busy_cycles);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done_a) break;
        end
        #1;
        check("a_done_reached", done_a, 1);
        busy_cycles = busy_tot - b0;
    endtask

    int b0;
    int bc;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_fc", fc_a, 0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Matching LUT
        tt_a = 8'hE3;
        b0 = busy_tot;
        pulse_a();
        wait_done_a(b0, bc);
        check("e3_busy_cycles", bc, 32);
        check("e3_pass", pass_a, 1);
        check("e3_fc", fc_a, 0);
        check("e3_fi", fi_a, 0);
        repeat (5) @(negedge clk);
        #1;
        check("done_held", done_a, 1);

        // One flipped bit
        tt_a = 8'hE7;
        pulse_a();
        wait_done_a(busy_tot, bc);
        check("e7_pass", pass_a, 0);
        check("e7_fc", fc_a, 1);
        check("e7_fi", fi_a, 2);

        // Constant-0 LUT
        tt_a = 8'h00;
        pulse_a();
        wait_done_a(busy_tot, bc);
        check("zero_fc", fc_a, 5);
        check("zero_fi", fi_a, 0);
        check("zero_pass", pass_a, 0);

        // Second start mid-sweep is ignored
        tt_a = 8'hE3;
        b0 = busy_tot;
        pulse_a();
        repeat (9) @(posedge clk);
        pulse_a();
        wait_done_a(b0, bc);
        check("restart_busy_cycles", bc, 32);
        check("restart_pass", pass_a, 1);

        // Asynchronous reset in the middle of a sweep
        tt_a = 8'hE7;
        pulse_a();
        repeat (12) @(posedge clk);
        #2;
        rst = 1'b1;
        m_started = 1'b0;
        #1;
        check("arst_busy", busy_a, 0);
        check("arst_lut_i", lut_i_a, 0);
        check("arst_done", done_a, 0);
        check("arst_pass", pass_a, 0);
        check("arst_fc", fc_a, 0);
        check("arst_fi", fi_a, 0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        b0 = busy_tot;
        pulse_a();
        wait_done_a(b0, bc);
        check("post_rst_busy_cycles", bc, 32);
        check("post_rst_fc", fc_a, 1);
        check("post_rst_fi", fi_a, 2);

        // Care mask hides every mismatch of the constant-0 LUT
        @(negedge clk);
        #1;
        start_b = 1'b1;
        @(posedge clk);
        #1;
        start_b = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done_b) break;
        end
        check("b_done", done_b, 1);
        check("b_pass", pass_b, 1);
        check("b_fc", fc_b, 0);
        check("b_fi", fi_b, 0);
        check("b_busy", busy_b, 0);
        check("b_lut_i", lut_i_b, 0);

        // Two-input XOR, vector advances every cycle
        @(negedge clk);
        #1;
        start_c = 1'b1;
        @(posedge clk);
        #1;
        start_c = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("c_busy", busy_c, 1);
            check("c_lut_i", lut_i_c, i);
        end
        @(negedge clk);
        check("c_busy_end", busy_c, 0);
        check("c_done", done_c, 1);
        check("c_pass", pass_c, 1);
        check("c_fc", fc_c, 0);
        check("c_fi", fi_c, 0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
